// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hard-wired control sequencer.
// States, enable/busSelect bit positions, opcodes and ALU codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MULDIV,
    CLS_ILLEGAL
  } cls_e;

  // enable bit positions (R0-R15 occupy 0-15)
  localparam int EN_HI  = 16;
  localparam int EN_LO  = 17;
  localparam int EN_Z   = 18;
  localparam int EN_Y   = 19;
  localparam int EN_PC  = 20;
  localparam int EN_MDR = 21;
  localparam int EN_IR  = 24;
  localparam int EN_MAR = 25;

  // busSelect bit positions (R0-R15 occupy 0-15)
  localparam int BS_HI  = 16;
  localparam int BS_LO  = 17;
  localparam int BS_ZHI = 18;
  localparam int BS_ZLO = 19;
  localparam int BS_PC  = 20;
  localparam int BS_MDR = 21;

  localparam logic [4:0] OP_ADD = 5'd3;
  localparam logic [4:0] OP_SUB = 5'd4;
  localparam logic [4:0] OP_AND = 5'd5;
  localparam logic [4:0] OP_OR  = 5'd6;
  localparam logic [4:0] OP_MUL = 5'd15;
  localparam logic [4:0] OP_DIV = 5'd16;

  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_AND = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_MUL = 4'd12;
  localparam logic [3:0] ALU_DIV = 4'd13;
  localparam logic [3:0] ALU_INC = 4'd14;

endpackage

// File: rtl/instr_decoder.sv
// Combinational IR decode: instruction class, ALU code, one-hot ra/rb/rc.
// Ports: ir in; cls, alu_code, ra_oh, rb_oh, rc_oh out.
module instr_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] ir,
  output cls_e              cls,
  output logic [3:0]        alu_code,
  output logic [DATA_W-1:0] ra_oh,
  output logic [DATA_W-1:0] rb_oh,
  output logic [DATA_W-1:0] rc_oh
);

  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir;

  assign ra_oh = DATA_W'(1) << ra;
  assign rb_oh = DATA_W'(1) << rb;
  assign rc_oh = DATA_W'(1) << rc;

  always_comb begin
    cls      = CLS_ILLEGAL;
    alu_code = '0;
    unique case (1'b1)
      (opcode == OP_ADD): begin
        cls      = CLS_ALU;
        alu_code = ALU_ADD;
      end
      (opcode == OP_SUB): begin
        cls      = CLS_ALU;
        alu_code = ALU_SUB;
      end
      (opcode == OP_AND): begin
        cls      = CLS_ALU;
        alu_code = ALU_AND;
      end
      (opcode == OP_OR): begin
        cls      = CLS_ALU;
        alu_code = ALU_OR;
      end
      (opcode == OP_MUL): begin
        cls      = CLS_MULDIV;
        alu_code = ALU_MUL;
      end
      (opcode == OP_DIV): begin
        cls      = CLS_MULDIV;
        alu_code = ALU_DIV;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired T0-T6 control unit: fetch, then ALU or MUL/DIV execute.
// Ports: clk, clr, run, mem_rdy, ir in; datapath strobes, done, illegal out.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] enable,
  output logic [DATA_W-1:0] busSelect,
  output logic              MD_Read,
  output logic [3:0]        Control_Signals,
  output logic              done,
  output logic              illegal
);

  state_e            state_q;
  state_e            state_d;
  state_e            final_next;
  cls_e              cls;
  logic [3:0]        alu_code;
  logic [DATA_W-1:0] ra_oh;
  logic [DATA_W-1:0] rb_oh;
  logic [DATA_W-1:0] rc_oh;

  instr_decoder #(
    .DATA_W(DATA_W)
  ) u_dec (
    .ir      (ir),
    .cls     (cls),
    .alu_code(alu_code),
    .ra_oh   (ra_oh),
    .rb_oh   (rb_oh),
    .rc_oh   (rc_oh)
  );

  // run only matters on the way out of a final state
  assign final_next = run ? S_T0 : S_IDLE;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    enable          = '0;
    busSelect       = '0;
    MD_Read         = 1'b0;
    Control_Signals = '0;
    done            = 1'b0;
    illegal         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T0;
      end
      S_T0: begin
        busSelect[BS_PC] = 1'b1;
        enable[EN_MAR]   = 1'b1;
        enable[EN_Z]     = 1'b1;
        Control_Signals  = ALU_INC;
        state_d          = S_T1;
      end
      S_T1: begin
        busSelect[BS_ZLO] = 1'b1;
        enable[EN_PC]     = 1'b1;
        enable[EN_MDR]    = 1'b1;
        MD_Read           = 1'b1;
        if (mem_rdy) state_d = S_T2;
      end
      S_T2: begin
        busSelect[BS_MDR] = 1'b1;
        enable[EN_IR]     = 1'b1;
        state_d           = S_T3;
      end
      S_T3: begin
        unique case (cls)
          CLS_ALU: begin
            busSelect    = rb_oh;
            enable[EN_Y] = 1'b1;
            state_d      = S_T4;
          end
          CLS_MULDIV: begin
            busSelect    = ra_oh;
            enable[EN_Y] = 1'b1;
            state_d      = S_T4;
          end
          default: begin
            illegal = 1'b1;
            state_d = final_next;
          end
        endcase
      end
      S_T4: begin
        Control_Signals = alu_code;
        state_d         = S_T5;
        unique case (cls)
          CLS_ALU: begin
            busSelect    = rc_oh;
            enable[EN_Z] = 1'b1;
          end
          CLS_MULDIV: begin
            busSelect    = rb_oh;
            enable[EN_Z] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        busSelect[BS_ZLO] = 1'b1;
        unique case (cls)
          CLS_ALU: begin
            enable  = ra_oh;
            done    = 1'b1;
            state_d = final_next;
          end
          CLS_MULDIV: begin
            enable[EN_LO] = 1'b1;
            state_d       = S_T6;
          end
          default: begin
            state_d = final_next;
          end
        endcase
      end
      S_T6: begin
        busSelect[BS_ZHI] = 1'b1;
        enable[EN_HI]     = 1'b1;
        done              = 1'b1;
        state_d           = final_next;
      end
    endcase
  end

endmodule
